// File: rtl/dsi_lane_striper.sv
// Packet-granular HS/LP arbiter that stripes granted packet bytes across the active DSI lanes
// and writes per-lane {lpm, data} entries into the four lane FIFOs.
module dsi_lane_striper #(
    parameter int unsigned LANES_MAX = 4
) (
    input  logic                   clk_phy,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [2:0]             reg_lanes_number,
    input  logic                   hs_valid,
    input  logic [31:0]            hs_data,
    input  logic                   hs_last,
    input  logic [1:0]             hs_last_bytes,
    output logic                   hs_ready,
    input  logic                   lp_valid,
    input  logic [31:0]            lp_data,
    input  logic                   lp_last,
    input  logic [1:0]             lp_last_bytes,
    output logic                   lp_ready,
    output logic [LANES_MAX*9-1:0] lane_fifo_data,
    output logic [LANES_MAX-1:0]   lane_fifo_write,
    input  logic [LANES_MAX-1:0]   lane_fifo_full,
    output logic [1:0]             grant,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_t;

    state_t      state_q;
    logic [55:0] buf_q;      // byte i at [8*i+7:8*i]; bytes at or above count_q are kept zero
    logic [2:0]  count_q;
    logic [2:0]  n_q;
    logic        lpm_q;
    logic [1:0]  grant_q;
    logic        rr_q;       // 0 = HS next on contention, 1 = LP

    logic [2:0]  n_map;
    logic        sel_last;
    logic [1:0]  sel_lb;
    logic [31:0] sel_data;
    logic        can_take;
    logic        accept;
    logic [2:0]  added;
    logic [31:0] word_mask;
    logic [2:0]  emit_m;
    logic [LANES_MAX-1:0] emit_mask;
    logic        want_emit;
    logic        emit;
    logic [2:0]  m_eff;
    logic [2:0]  rem;
    logic [2:0]  count_d;
    logic [55:0] buf_d;
    logic        pick_lp;

    always_comb begin
        case (reg_lanes_number)
            3'd0:                      n_map = 3'd1;
            3'd1, 3'd2, 3'd3, 3'd4:    n_map = reg_lanes_number;
            default:                   n_map = 3'd4;
        endcase
    end

    assign sel_last = grant_q[1] ? lp_last : hs_last;
    assign sel_lb   = grant_q[1] ? lp_last_bytes : hs_last_bytes;
    assign sel_data = grant_q[1] ? lp_data : hs_data;

    // Registered count only: no same-cycle credit from a concurrent emit.
    assign can_take = (state_q == StXfer) && (count_q <= 3'd3);
    assign hs_ready = can_take && grant_q[0];
    assign lp_ready = can_take && grant_q[1];
    assign accept   = (hs_ready && hs_valid) || (lp_ready && lp_valid);

    always_comb begin
        added = 3'd0;
        if (accept) begin
            added = sel_last ? ({1'b0, sel_lb} + 3'd1) : 3'd4;
        end
        case (added)
            3'd1:    word_mask = 32'h0000_00ff;
            3'd2:    word_mask = 32'h0000_ffff;
            3'd3:    word_mask = 32'h00ff_ffff;
            3'd4:    word_mask = 32'hffff_ffff;
            default: word_mask = 32'h0000_0000;
        endcase
    end

    assign emit_m    = (count_q < n_q) ? count_q : n_q;
    assign want_emit = (count_q != 3'd0) && ((count_q >= n_q) || (state_q == StDrain));

    always_comb begin
        emit_mask = '0;
        for (int i = 0; i < int'(LANES_MAX); i++) begin
            emit_mask[i] = (int'(emit_m) > i);
        end
    end

    // A full lane anywhere in the target group holds back the whole group.
    assign emit  = want_emit && ((lane_fifo_full & emit_mask) == '0);
    assign m_eff = emit ? emit_m : 3'd0;

    always_comb begin
        lane_fifo_data  = '0;
        lane_fifo_write = '0;
        for (int i = 0; i < int'(LANES_MAX); i++) begin
            if (emit && emit_mask[i]) begin
                lane_fifo_write[i]    = 1'b1;
                lane_fifo_data[i*9 +: 9] = {lpm_q, buf_q[i*8 +: 8]};
            end
        end
    end

    assign rem     = count_q - m_eff;
    assign count_d = rem + added;
    assign buf_d   = (buf_q >> {m_eff, 3'b000}) | (56'(sel_data & word_mask) << {rem, 3'b000});

    assign pick_lp = (hs_valid && lp_valid) ? rr_q : lp_valid;

    always_ff @(posedge clk_phy) begin
        if (rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            count_q <= 3'd0;
            n_q     <= 3'd1;
            lpm_q   <= 1'b0;
            grant_q <= 2'b00;
            rr_q    <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            case (state_q)
                StIdle: begin
                    if (enable && (hs_valid || lp_valid)) begin
                        grant_q <= pick_lp ? 2'b10 : 2'b01;
                        lpm_q   <= pick_lp;
                        rr_q    <= ~pick_lp;
                        n_q     <= n_map;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (accept && sel_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (count_d == 3'd0) begin
                        grant_q <= 2'b00;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dsi_lane_striper.sv
// Directed bench for dsi_lane_striper: every lane write is logged and compared against
// hand-computed expected entries.
module tb_dsi_lane_striper;

    logic        clk_phy;
    logic        rst;
    logic        enable;
    logic [2:0]  reg_lanes_number;
    logic        hs_valid, lp_valid;
    logic [31:0] hs_data, lp_data;
    logic        hs_last, lp_last;
    logic [1:0]  hs_last_bytes, lp_last_bytes;
    logic        hs_ready, lp_ready;
    logic [35:0] lane_fifo_data;
    logic [3:0]  lane_fifo_write;
    logic [3:0]  lane_fifo_full;
    logic [1:0]  grant;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] wq[$];
    logic [39:0] exp_q[$];
    logic [31:0] pkt_w[8];

    dsi_lane_striper #(.LANES_MAX(4)) dut (
        .clk_phy          (clk_phy),
        .rst              (rst),
        .enable           (enable),
        .reg_lanes_number (reg_lanes_number),
        .hs_valid         (hs_valid),
        .hs_data          (hs_data),
        .hs_last          (hs_last),
        .hs_last_bytes    (hs_last_bytes),
        .hs_ready         (hs_ready),
        .lp_valid         (lp_valid),
        .lp_data          (lp_data),
        .lp_last          (lp_last),
        .lp_last_bytes    (lp_last_bytes),
        .lp_ready         (lp_ready),
        .lane_fifo_data   (lane_fifo_data),
        .lane_fifo_write  (lane_fifo_write),
        .lane_fifo_full   (lane_fifo_full),
        .grant            (grant),
        .busy             (busy)
    );

    initial begin
        clk_phy = 1'b0;
        forever #5 clk_phy = ~clk_phy;
    end

    always @(negedge clk_phy) begin
        if (lane_fifo_write != 4'b0000) wq.push_back({lane_fifo_write, lane_fifo_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic lpm, input int m, input logic [31:0] bytes);
        logic [35:0] d;
        logic [3:0]  w;
        d = '0;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < m) begin
                w[i]       = 1'b1;
                d[i*9 +: 9] = {lpm, bytes[i*8 +: 8]};
            end
        end
        return {w, d};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_phy);
        #1 rst = 1'b0;
    endtask

    // Presents pkt_w[0..nw-1] on one source; returns at posedge+1 after the final accept.
    task automatic send_pkt(input bit lp, input int nw, input logic [1:0] lb, input bit set_last);
        bit acc;
        for (int w = 0; w < nw; w++) begin
            if (lp) begin
                lp_valid = 1'b1; lp_data = pkt_w[w];
                lp_last = set_last && (w == nw - 1); lp_last_bytes = lb;
            end else begin
                hs_valid = 1'b1; hs_data = pkt_w[w];
                hs_last = set_last && (w == nw - 1); hs_last_bytes = lb;
            end
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk_phy);
                acc = lp ? lp_ready : hs_ready;
                @(posedge clk_phy);
                #1;
            end
            if (!acc) check("accept_timeout", 0, 1);
        end
        hs_valid = 1'b0; hs_last = 1'b0;
        lp_valid = 1'b0; lp_last = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk_phy);
            done = !busy;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        @(posedge clk_phy);
        #1;
        check({tag, "_nwrites"}, wq.size(), exp_q.size());
        n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), wq[i], exp_q[i]);
        wq.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int acc_cnt;
        bit rh, rl;
        logic [31:0] hs_words[2];
        logic [31:0] lp_words[2];
        int hs_i, lp_i;
        bit order[$];

        rst = 1'b1; enable = 1'b1; reg_lanes_number = 3'd4;
        hs_valid = 0; lp_valid = 0; hs_data = 0; lp_data = 0;
        hs_last = 0; lp_last = 0; hs_last_bytes = 0; lp_last_bytes = 0;
        lane_fifo_full = 4'b0000;
        do_reset();

        @(negedge clk_phy);
        check("rst_write", lane_fifo_write, 4'b0);
        check("rst_data", lane_fifo_data, 36'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", {hs_ready, lp_ready}, 2'b00);

        // enable=0 blocks new grants
        @(posedge clk_phy); #1;
        enable = 1'b0; hs_valid = 1'b1;
        repeat (3) @(posedge clk_phy);
        @(negedge clk_phy);
        check("disabled_busy", busy, 1'b0);
        check("disabled_grant", grant, 2'b00);
        @(posedge clk_phy); #1;
        enable = 1'b1; hs_valid = 1'b0;
        wq.delete();

        // 1: N=4 HS two words
        reg_lanes_number = 3'd4;
        pkt_w[0] = 32'h44332211; pkt_w[1] = 32'h88776655;
        send_pkt(0, 2, 2'd3, 1);
        @(negedge clk_phy);
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1'b1);
        wait_idle();
        check("t1_grant_idle", grant, 2'b00);
        exp_q.push_back(mk(0, 4, 32'h44332211));
        exp_q.push_back(mk(0, 4, 32'h88776655));
        compare_writes("t1");

        // 2: N=2 LP one word
        reg_lanes_number = 3'd2;
        pkt_w[0] = 32'h44332211;
        send_pkt(1, 1, 2'd3, 1);
        @(negedge clk_phy);
        check("t2_grant", grant, 2'b10);
        check("t2_lp_ready", lp_ready, 1'b0);
        wait_idle();
        exp_q.push_back(mk(1, 2, 32'h2211));
        exp_q.push_back(mk(1, 2, 32'h4433));
        compare_writes("t2");

        // 3: N=3, 7 bytes
        reg_lanes_number = 3'd3;
        pkt_w[0] = 32'h04030201; pkt_w[1] = 32'h00070605;
        send_pkt(0, 2, 2'd2, 1);
        wait_idle();
        exp_q.push_back(mk(0, 3, 32'h030201));
        exp_q.push_back(mk(0, 3, 32'h060504));
        exp_q.push_back(mk(0, 1, 32'h07));
        compare_writes("t3");

        // 4: both sources contending from reset, N=0 acts as 1
        do_reset();
        reg_lanes_number = 3'd0;
        hs_words[0] = 32'ha3a2a1a0; hs_words[1] = 32'hb3b2b1b0;
        lp_words[0] = 32'hc3c2c1c0; lp_words[1] = 32'hd3d2d1d0;
        hs_i = 0; lp_i = 0; acc_cnt = 0;
        hs_valid = 1; hs_data = hs_words[0]; hs_last = 1; hs_last_bytes = 2'd3;
        lp_valid = 1; lp_data = lp_words[0]; lp_last = 1; lp_last_bytes = 2'd3;
        for (int t = 0; t < 400 && acc_cnt < 4; t++) begin
            @(negedge clk_phy);
            rh = hs_ready && hs_valid;
            rl = lp_ready && lp_valid;
            @(posedge clk_phy);
            #1;
            if (rh) begin
                order.push_back(1'b0); acc_cnt++; hs_i++;
                hs_data = hs_words[hs_i % 2];
            end
            if (rl) begin
                order.push_back(1'b1); acc_cnt++; lp_i++;
                lp_data = lp_words[lp_i % 2];
            end
        end
        hs_valid = 0; lp_valid = 0; hs_last = 0; lp_last = 0;
        check("t4_accepts", acc_cnt, 4);
        for (int k = 0; k < 4 && k < order.size(); k++) check($sformatf("t4_order%0d", k), order[k], k % 2);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            case (k)
                0: w = hs_words[0];
                1: w = lp_words[0];
                2: w = hs_words[1];
                default: w = lp_words[1];
            endcase
            for (int b = 0; b < 4; b++) exp_q.push_back(mk(k % 2, 1, {24'b0, w[b*8 +: 8]}));
        end
        compare_writes("t4");

        // 5: N=2 with lane 1 held full mid-packet
        reg_lanes_number = 3'd2;
        pkt_w[0] = 32'h44332211; pkt_w[1] = 32'h88776655; pkt_w[2] = 32'hccbbaa99;
        fork
            send_pkt(0, 3, 2'd3, 1);
            begin
                repeat (3) @(posedge clk_phy);
                #1 lane_fifo_full = 4'b0010;
                n0 = wq.size();
                repeat (9) @(posedge clk_phy);
                @(negedge clk_phy);
                check("t5_stall_ready", hs_ready, 1'b0);
                check("t5_stall_nowrite", wq.size(), n0);
                @(posedge clk_phy);
                #1 lane_fifo_full = 4'b0000;
            end
        join
        wait_idle();
        exp_q.push_back(mk(0, 2, 32'h2211));
        exp_q.push_back(mk(0, 2, 32'h4433));
        exp_q.push_back(mk(0, 2, 32'h6655));
        exp_q.push_back(mk(0, 2, 32'h8877));
        exp_q.push_back(mk(0, 2, 32'haa99));
        exp_q.push_back(mk(0, 2, 32'hccbb));
        compare_writes("t5");

        // 6: reset while the third word is presented
        reg_lanes_number = 3'd4;
        pkt_w[0] = 32'h11111111; pkt_w[1] = 32'h22222222;
        send_pkt(0, 2, 2'd3, 0);
        hs_valid = 1; hs_data = 32'h33333333; hs_last = 1; hs_last_bytes = 2'd3;
        rst = 1'b1;
        @(negedge clk_phy);
        check("t6_busy_before", busy, 1'b1);
        @(posedge clk_phy);
        #1 rst = 1'b0; hs_valid = 0; hs_last = 0;
        @(negedge clk_phy);
        check("t6_write", lane_fifo_write, 4'b0);
        check("t6_data", lane_fifo_data, 36'b0);
        check("t6_grant", grant, 2'b00);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", {hs_ready, lp_ready}, 2'b00);
        @(posedge clk_phy);
        #1;
        wq.delete();
        reg_lanes_number = 3'd7;
        pkt_w[0] = 32'h0d0c0b0a;
        send_pkt(0, 1, 2'd1, 1);
        wait_idle();
        exp_q.push_back(mk(0, 2, 32'h0b0a));
        compare_writes("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_lane_striper.md
Name: dsi_lane_striper

Overview:
- Arbitrates between two packet sources (HS video stream, LP command stream) at packet granularity.
- Stripes each granted packet's bytes across the active data lanes (byte k → lane k mod N).
- Writes the per-lane 9-bit entries (8 data + LP-mode flag) into the four lane FIFOs consumed by dsi_lanes_controller.
- Sits between the packet assembler and the lane FIFOs, in the clk_phy domain.

Parameters:
- LANES_MAX, 4, number of lane FIFO slots (fixed 4; lane i occupies bits [i*9+8:i*9]).

Ports:
- clk_phy  in  1  phy logic clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  allow new grants; a packet in progress always completes.
- reg_lanes_number  in  3  active lane count N; sampled at grant only.
- hs_valid  in  1  HS source word valid.
- hs_data  in  32  HS word; byte 0 = [7:0] is sent first.
- hs_last  in  1  last word of the HS packet.
- hs_last_bytes  in  2  valid bytes in the last word minus 1.
- hs_ready  out  1  HS word accepted when valid && ready.
- lp_valid, lp_data, lp_last, lp_last_bytes, lp_ready  same as the hs_* ports, for the LP command source.
- lane_fifo_data  out  36  lane i: [i*9+7:i*9] data, [i*9+8] lpm (1 = LP source).
- lane_fifo_write  out  4  per-lane write strobe.
- lane_fifo_full  in  4  per-lane FIFO full.
- grant  out  2  one-hot: [0] = HS, [1] = LP; 00 when idle.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset:** all outputs 0, state IDLE, byte buffer cleared, round-robin pointer = HS. Reset mid-packet discards all buffered bytes; there is no partial flush.
- **N mapping:** N = reg_lanes_number, with 0 treated as 1 and 5..7 treated as 4. N is latched at grant and held for the whole packet.
- **FSM IDLE:** if enable and any source valid, grant that source, latch N and lpm, go to XFER.
  - Both valid: grant the source at the round-robin pointer.
  - On every grant, the pointer moves to the other source.
- **FSM XFER:** accept words. After accepting the word with last=1, go to DRAIN.
- **FSM DRAIN:** emit the remaining bytes. When the buffer is empty, go to IDLE and clear grant.
  - There is at least one IDLE cycle between packets.
- **Byte buffer:** FIFO of up to 7 bytes; count is a registered 3-bit value.
- **Accept (ready):**
  - ready[g] = (state == XFER) && grant[g] && (count <= 3); this uses the registered count, with no bypass.
  - A non-last word adds 4 bytes; a last word adds last_bytes + 1 bytes.
- **Emit:**
  - Emit size m = min(N, count).
  - Emit when count >= N, or when (state == DRAIN && count > 0).
  - Emit only if lane_fifo_full[m-1:0] == 0. The group is written atomically to lanes 0..m-1, with buffer bytes in FIFO order.
  - lane_fifo_write = m low bits set. Data and lpm for unwritten lanes = 0.
  - Outputs are registered: a word accepted at cycle t gives its earliest write at t+1.
- **Same cycle:** accept and emit may occur together; count_next = count + added - m. Max count 7, so no overflow is possible.
- **Stall:** any full lane in the target group stalls the whole group; lanes are never written partially out of order.
- **Source rules:** neither source is granted while busy. A valid not granted has no effect. The last flag on the granted source terminates the packet regardless of word count.

Test Plan:
1. N=4, HS packet 0x44332211 then 0x88776655 (last, last_bytes=3) → two write cycles, write=1111. Lane0 gets 0x11 then 0x55; lane3 gets 0x44 then 0x88; all lpm=0; grant=01 during the packet, then 00.
2. N=2, LP packet 0x44332211 (last, last_bytes=3) → cycle 1: write=0011, lane0=0x11, lane1=0x22, lpm bits=1. Cycle 2: lane0=0x33, lane1=0x44. lp_ready then low until IDLE.
3. N=3, words 0x04030201 and 0x00070605 (last, last_bytes=2) → write 0111 (01,02,03), write 0111 (04,05,06), write 0001 (07).
4. hs_valid and lp_valid both held high, each with 1-word packets, from reset → grants HS, LP, HS, LP. reg_lanes_number=0 behaves as N=1, giving four single-lane writes per word.
5. N=2, lane_fifo_full[1]=1 for 10 cycles mid-packet → no writes; ready low once count > 3. After release, byte order on the lanes is unchanged and no byte is lost or duplicated.
6. rst asserted in the middle of the 3rd word → next cycle all outputs 0, busy=0. A following packet starts cleanly at lane 0.
